// File: rtl/video_fetch_ctrl_pkg.sv
// rtl/video_fetch_ctrl_pkg.sv - shared types and constants for the video fetch controller
// Purpose: fetch FSM state encoding, framebuffer word geometry and a byte-select helper.
// Ports: none (package).
package video_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_t;

  localparam int BYTES_PER_WORD = 4;

  // Little-endian byte lane select: lane 0 is bits [7:0].
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] lane);
    return word[8*lane +: 8];
  endfunction

endpackage

// File: rtl/video_word_fifo.sv
// rtl/video_word_fifo.sv - single-clock 32-bit word FIFO with registered head
// Purpose: buffers fetched framebuffer words between the bus and the byte serializer.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   flush           - empty the FIFO (wins over push/pop)
//   push, push_data - write one word (ignored when full)
//   pop             - drop the head word (ignored when empty)
//   head            - registered head word
//   head_next       - value head takes at the next edge (lets the consumer register ahead)
//   count, full, empty - occupancy
module video_word_fifo #(
  parameter int C_fifo_log2 = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [31:0]            push_data,
  input  logic                   pop,
  output logic [31:0]            head,
  output logic [31:0]            head_next,
  output logic [C_fifo_log2:0]   count,
  output logic                   full,
  output logic                   empty
);

  localparam int DEPTH = 2 ** C_fifo_log2;

  logic [31:0]            mem [DEPTH];
  logic [C_fifo_log2-1:0] rd_ptr;
  logic [C_fifo_log2-1:0] wr_ptr;
  logic [C_fifo_log2-1:0] rd_ptr_inc;
  logic                   do_push;
  logic                   do_pop;

  assign full       = (count == (C_fifo_log2+1)'(DEPTH));
  assign empty      = (count == '0);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign rd_ptr_inc = rd_ptr + 1'b1;

  // Next head: the word behind the current head if one is stored, otherwise
  // the word being pushed this cycle (either into an empty FIFO, or racing a
  // pop of the last stored word).
  always_comb begin
    head_next = head;
    if (!flush) begin
      if (do_pop) begin
        if (count > (C_fifo_log2+1)'(1))
          head_next = mem[rd_ptr_inc];
        else if (do_push)
          head_next = push_data;
      end else if (do_push && empty) begin
        head_next = push_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && do_push)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr_inc;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      head <= head_next;
    end
  end

endmodule

// File: rtl/video_fetch_ctrl.sv
// rtl/video_fetch_ctrl.sv - bus-master fetcher feeding the display pixel byte stream
// Purpose: fetches framebuffer words over the memory bus into a word FIFO and
//          serves them one byte per rd pulse; restarts on every vsync falling edge.
// Ports:
//   clk, reset                       - CPU clock, synchronous active-high reset
//   base_addr                        - framebuffer word address, sampled at frame start
//   vga_vsync                        - active-low vsync, asynchronous to clk
//   rd                               - one-clk pulse: current byte consumed
//   disp_data                        - registered current pixel byte
//   bus_addr_strobe, bus_addr        - read request and its word address
//   bus_data_ready, bus_data         - one-clk acknowledge with read data
//   underflow                        - sticky: rd seen while FIFO empty
module video_fetch_ctrl
  import video_fetch_ctrl_pkg::*;
#(
  parameter int C_addr_bits   = 30,
  parameter int C_fifo_log2   = 4,
  parameter int C_frame_words = 9600,
  parameter int C_sync_stages = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [C_addr_bits-3:0] base_addr,
  input  logic                   vga_vsync,
  input  logic                   rd,
  output logic [7:0]             disp_data,
  output logic                   bus_addr_strobe,
  output logic [C_addr_bits-3:0] bus_addr,
  input  logic                   bus_data_ready,
  input  logic [31:0]            bus_data,
  output logic                   underflow
);

  localparam int WCW = $clog2(C_frame_words + 1);

  // vsync synchronizer plus edge-detect flop; reset to the idle-high level so
  // leaving reset never looks like a falling edge.
  logic [C_sync_stages-1:0] vsync_sync;
  logic                     vsync_prev;
  logic                     frame_start;

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_sync <= '1;
      vsync_prev <= 1'b1;
    end else begin
      vsync_sync <= {vsync_sync[C_sync_stages-2:0], vga_vsync};
      vsync_prev <= vsync_sync[C_sync_stages-1];
    end
  end

  assign frame_start = vsync_prev && !vsync_sync[C_sync_stages-1];

  // Word FIFO
  logic [31:0]          head;
  logic [31:0]          head_next;
  logic [C_fifo_log2:0] fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;

  video_word_fifo #(
    .C_fifo_log2 (C_fifo_log2)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (frame_start),
    .push      (push),
    .push_data (bus_data),
    .pop       (pop),
    .head      (head),
    .head_next (head_next),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Fetch FSM
  fetch_state_t           state;
  fetch_state_t           state_next;
  logic [C_addr_bits-3:0] fetch_ptr;
  logic [WCW-1:0]         word_cnt;

  always_comb begin
    state_next = state;
    push       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!frame_start && (word_cnt < WCW'(C_frame_words)) && !fifo_full)
          state_next = ST_REQ;
      end
      ST_REQ: begin
        // A request cannot be withdrawn, so a frame restart while it is
        // pending waits out the acknowledge and drops that word.
        if (frame_start)
          state_next = bus_data_ready ? ST_IDLE : ST_DISCARD;
        else if (bus_data_ready) begin
          push       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (bus_data_ready)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus_addr_strobe = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      fetch_ptr <= '0;
      bus_addr  <= '0;
      word_cnt  <= '0;
    end else begin
      state <= state_next;
      if (frame_start) begin
        fetch_ptr <= base_addr;
        word_cnt  <= '0;
      end else if (push) begin
        fetch_ptr <= fetch_ptr + 1'b1;
        word_cnt  <= word_cnt + 1'b1;
      end
      if (state == ST_IDLE && state_next == ST_REQ)
        bus_addr <= fetch_ptr;
    end
  end

  // Byte serializer
  logic [1:0] byte_idx;
  logic       rd_ok;
  logic       last_byte;

  assign rd_ok     = rd && !fifo_empty && !frame_start;
  assign last_byte = (byte_idx == 2'(BYTES_PER_WORD - 1));
  assign pop       = rd_ok && last_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx  <= '0;
      disp_data <= '0;
      underflow <= 1'b0;
    end else if (frame_start) begin
      // disp_data deliberately holds until the new frame's first word lands.
      byte_idx  <= '0;
      underflow <= 1'b0;
    end else begin
      if (rd && fifo_empty)
        underflow <= 1'b1;
      if (rd_ok) begin
        byte_idx <= byte_idx + 1'b1;
        if (!last_byte)
          disp_data <= word_byte(head, byte_idx + 2'd1);
        else if (fifo_count > (C_fifo_log2+1)'(1) || push)
          disp_data <= head_next[7:0];
      end else if (push && fifo_empty) begin
        disp_data <= bus_data[7:0];
      end
    end
  end

endmodule

// File: tb/tb_video_fetch_ctrl.sv
// tb/tb_video_fetch_ctrl.sv - self-checking bench for video_fetch_ctrl
module tb_video_fetch_ctrl;

  localparam int AB    = 30;
  localparam int FL    = 4;
  localparam int FW    = 20;
  localparam int SS    = 2;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [27:0] base_addr;
  logic        vga_vsync;
  logic        rd;
  logic [7:0]  disp_data;
  logic        bus_addr_strobe;
  logic [27:0] bus_addr;
  logic        bus_data_ready;
  logic [31:0] bus_data;
  logic        underflow;

  always #5 clk = ~clk;

  video_fetch_ctrl #(
    .C_addr_bits   (AB),
    .C_fifo_log2   (FL),
    .C_frame_words (FW),
    .C_sync_stages (SS)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .base_addr       (base_addr),
    .vga_vsync       (vga_vsync),
    .rd              (rd),
    .disp_data       (disp_data),
    .bus_addr_strobe (bus_addr_strobe),
    .bus_addr        (bus_addr),
    .bus_data_ready  (bus_data_ready),
    .bus_data        (bus_data),
    .underflow       (underflow)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  function automatic logic [31:0] mem_word(input logic [27:0] a);
    logic [31:0] d;
    d = {4'b0, a} - 32'h100;
    return 32'h44332211 + d * 32'h04040404;
  endfunction

  // Bench-side state
  int          edge_cnt = 0;
  int          fs_edge  = -1;
  logic [31:0] m_q[$];
  int          m_idx;
  logic [7:0]  m_disp;
  logic        m_uf;
  logic [27:0] m_ptr;
  int          m_wc;
  bit          m_discard;
  int          frame_reqs = 0;

  int          lat = 3;
  bit          busy = 0;
  int          cnt;
  logic [27:0] ack_addr;
  bit          cap_next = 0;
  bit          cap_done = 0;
  logic [27:0] cap_addr;

  always @(posedge clk) edge_cnt++;

  // Behavioural model: byte stream from a word queue. Compares the state the
  // last edge produced, then applies what the coming edge will do.
  always @(negedge clk) begin : model
    logic [31:0] w;
    if (edge_cnt > 0) begin
      check("disp_data", disp_data, m_disp);
      check("underflow", underflow, m_uf);
    end
    if (reset) begin
      m_q.delete();
      m_idx = 0; m_disp = 8'h00; m_uf = 1'b0; m_ptr = '0; m_wc = 0; m_discard = 0;
    end else if (edge_cnt + 1 == fs_edge) begin
      m_discard = busy && !bus_data_ready;
      m_q.delete();
      m_idx = 0; m_uf = 1'b0; m_ptr = base_addr; m_wc = 0; frame_reqs = 0;
    end else begin
      if (rd) begin
        if (m_q.size() == 0) m_uf = 1'b1;
        else begin
          if (m_idx == 3) void'(m_q.pop_front());
          m_idx = (m_idx + 1) % 4;
        end
      end
      if (bus_data_ready) begin
        if (m_discard) m_discard = 0;
        else begin
          m_q.push_back(bus_data);
          m_ptr = m_ptr + 28'd1;
          m_wc++;
        end
      end
      if (m_q.size() > DEPTH) check("fifo_overflow", m_q.size(), DEPTH);
      if (m_q.size() > 0) begin
        w = m_q[0];
        m_disp = w[8*m_idx +: 8];
      end
    end
  end

  // Memory responder: acknowledges each request lat edges after it starts.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      busy = 0;
      bus_data_ready = 1'b0;
    end else if (bus_data_ready) begin
      bus_data_ready = 1'b0;
      busy = 0;
      check("strobe_gap", bus_addr_strobe, 1'b0);
    end else if (busy) begin
      check("strobe_held", bus_addr_strobe, 1'b1);
      check("addr_held", bus_addr, ack_addr);
    end else if (bus_addr_strobe) begin
      busy = 1;
      cnt = lat;
      ack_addr = bus_addr;
      frame_reqs++;
      check("req_addr", bus_addr, m_ptr);
      check("req_room", m_q.size() < DEPTH, 1);
      check("req_budget", m_wc < FW, 1);
      if (cap_next) begin
        cap_addr = bus_addr;
        cap_next = 0;
        cap_done = 1;
      end
    end
    if (busy && !bus_data_ready) begin
      cnt--;
      if (cnt <= 0) begin
        bus_data_ready = 1'b1;
        bus_data = mem_word(ack_addr);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic frame_pulse();
    vga_vsync = 1'b0;
    fs_edge = edge_cnt + SS + 1;
    tick(2);
    vga_vsync = 1'b1;
  endtask

  task automatic rd_pulse();
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
  endtask

  task automatic wait_qsize(input int n, input int budget, input string name);
    int k = 0;
    while (m_q.size() != n && k < budget) begin
      tick(1);
      k++;
    end
    if (k >= budget) timeout_fail(name);
  endtask

  initial begin
    int k;
    reset = 1'b1; vga_vsync = 1'b1; rd = 1'b0;
    bus_data_ready = 1'b0; bus_data = '0; base_addr = 28'h100;
    tick(3);
    check("rst_disp", disp_data, 8'h00);
    check("rst_strobe", bus_addr_strobe, 1'b0);
    check("rst_addr", bus_addr, 28'h0);
    check("rst_underflow", underflow, 1'b0);
    reset = 1'b0;

    // FIFO fills from the reset pointer, then stops while full
    wait_qsize(16, 300, "fill_after_reset");
    tick(5);
    check("full_no_strobe", bus_addr_strobe, 1'b0);

    // Frame at 0x100, 3-clk bus
    frame_pulse();
    tick(2);
    wait_qsize(16, 300, "fill_frame1");
    tick(10);
    check("frame1_full_strobe", bus_addr_strobe, 1'b0);
    check("frame1_reqs16", frame_reqs, 16);
    check("byte0", disp_data, 8'h11);
    rd_pulse(); check("byte1", disp_data, 8'h22);
    rd_pulse(); check("byte2", disp_data, 8'h33);
    rd_pulse(); check("byte3", disp_data, 8'h44);
    rd_pulse(); check("next_word_byte0", disp_data, 8'h15);
    check("no_underflow", underflow, 1'b0);
    tick(10);
    check("refill_req", frame_reqs, 17);

    // Consume faster than a slow bus refills
    lat = 20;
    rd = 1'b1;
    tick(200);
    rd = 1'b0;
    tick(2);
    check("underflow_set", underflow, 1'b1);
    check("frame_budget", frame_reqs, FW);
    check("saturated_strobe", bus_addr_strobe, 1'b0);

    // New frame clears underflow; vsync during a pending request discards it
    base_addr = 28'h200;
    lat = 5;
    frame_pulse();
    tick(2);
    check("underflow_cleared", underflow, 1'b0);
    k = 0;
    while (!bus_addr_strobe && k < 50) begin tick(1); k++; end
    if (k >= 50) timeout_fail("wait_req_0x200");
    base_addr = 28'h300;
    frame_pulse();
    cap_next = 1;
    k = 0;
    while (!cap_done && k < 50) begin tick(1); k++; end
    if (k >= 50) timeout_fail("wait_req_0x300");
    check("req_after_discard", cap_addr, 28'h300);
    rd_pulse();
    check("discard_left_empty", underflow, 1'b1);

    // Ack coinciding with the 4th rd on a 1-word FIFO
    lat = 8;
    base_addr = 28'h400;
    frame_pulse();
    tick(2);
    wait_qsize(1, 100, "first_word_0x400");
    rd_pulse(); rd_pulse(); rd_pulse();
    check("w400_byte3", disp_data, 8'h50);
    k = 0;
    while (!bus_data_ready && k < 50) begin tick(1); k++; end
    if (k >= 50) timeout_fail("wait_ack_0x401");
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
    check("same_cycle_byte0", disp_data, 8'h15);
    check("same_cycle_underflow", underflow, 1'b0);
    tick(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
